// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time from the pipeline, drives the
// D-cache request side while the access is pending, and returns an extended load
// result (or store acknowledgement) with misalignment and timeout flags.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_is_store,
    output logic        resp_misaligned,
    output logic        resp_timeout,

    output logic        dc_en,
    output logic [63:0] dc_in_addr,
    output logic        dc_write_en,
    output logic [63:0] dc_in_wdata,
    output logic [1:0]  dc_in_wlen,
    input  logic [63:0] dc_out_rdata,
    input  logic        dc_out_rvalid,
    input  logic        dc_out_write_done
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            to_q, to_d;

    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [4:0]  rd_q;
    logic        is_store_q;

    logic        accept;
    logic        misaligned;
    logic        done;
    logic [63:0] load_ext;

    assign accept = req_valid && (state_q == StIdle);
    // Only the strobe matching the op type counts; the other one is noise.
    assign done   = is_store_q ? dc_out_write_done : dc_out_rvalid;

    // Natural-alignment check on the incoming request.
    always_comb begin
        unique case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // Sign/zero extension of the returned load data by latched size.
    always_comb begin
        unique case (size_q)
            2'd0: load_ext = unsigned_q ? {56'b0, dc_out_rdata[7:0]}
                                        : {{56{dc_out_rdata[7]}}, dc_out_rdata[7:0]};
            2'd1: load_ext = unsigned_q ? {48'b0, dc_out_rdata[15:0]}
                                        : {{48{dc_out_rdata[15]}}, dc_out_rdata[15:0]};
            2'd2: load_ext = unsigned_q ? {32'b0, dc_out_rdata[31:0]}
                                        : {{32{dc_out_rdata[31]}}, dc_out_rdata[31:0]};
            default: load_ext = dc_out_rdata;
        endcase
    end

    // Next-state logic: sequencing, timeout counter and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rdata_d = '0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        mis_d   = 1'b0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                // Completion wins over timeout in the same cycle.
                if (done) begin
                    rdata_d = is_store_q ? 64'd0 : load_ext;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    // Request fields captured on acceptance and held for the whole op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            rd_q       <= req_rd;
            is_store_q <= req_is_store;
        end
    end

    // Handshake and D-cache outputs decoded from the registered state.
    always_comb begin
        req_ready       = (state_q == StIdle);
        resp_valid      = (state_q == StResp);
        dc_en           = (state_q == StAccess);
        dc_write_en     = (state_q == StAccess) && is_store_q;
        dc_in_addr      = addr_q;
        dc_in_wdata     = wdata_q;
        dc_in_wlen      = size_q;
        resp_rdata      = rdata_q;
        resp_rd         = rd_q;
        resp_is_store   = is_store_q;
        resp_misaligned = mis_q;
        resp_timeout    = to_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized ops
// against a reference model, and hand-written reset-during-access sequence.
module tb_load_store_unit;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_is_store, resp_misaligned, resp_timeout;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        dc_en, dc_write_en, dc_out_rvalid, dc_out_write_done;
    logic [63:0] dc_in_addr, dc_in_wdata, dc_out_rdata;
    logic [1:0]  dc_in_wlen;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_is_store(resp_is_store),
        .resp_misaligned(resp_misaligned), .resp_timeout(resp_timeout),
        .dc_en(dc_en), .dc_in_addr(dc_in_addr), .dc_write_en(dc_write_en),
        .dc_in_wdata(dc_in_wdata), .dc_in_wlen(dc_in_wlen),
        .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid),
        .dc_out_write_done(dc_out_write_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    typedef struct {
        logic        is_store;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        int          lat;      // access cycle in which the cache completes; 0 = never
        logic [63:0] raw;
        int          rdelay;   // cycles resp_ready is held low
        logic [63:0] exp_rdata;
        logic        exp_mis;
        logic        exp_to;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference extension using plain arithmetic on the value's bit width.
    function automatic logic [63:0] ref_ext(input logic [63:0] raw, input logic [1:0] size,
                                            input logic uns);
        longint unsigned bits, v, span;
        if (size == 2'd3) return raw;
        bits = 64'(8 << size);
        span = 64'd1 << bits;
        v = raw % span;
        if (!uns && v >= span / 2) v = v - span;
        return v;
    endfunction

    function automatic vec_t mk(input logic st, input logic [63:0] addr, input logic [63:0] wd,
                                input logic [1:0] size, input logic uns, input logic [4:0] rd,
                                input int lat, input logic [63:0] raw, input int rdelay,
                                input logic [63:0] er, input logic em, input logic et);
        vec_t v;
        v.is_store = st; v.addr = addr; v.wdata = wd; v.size = size; v.uns = uns; v.rd = rd;
        v.lat = lat; v.raw = raw; v.rdelay = rdelay;
        v.exp_rdata = er; v.exp_mis = em; v.exp_to = et;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Issues one op, plays the D-cache, and checks the response and handshakes.
    task automatic run_op(input vec_t v);
        int   acc, lat_seen, exp_acc;
        logic got, dc_ok, stab;
        logic [63:0] s_rdata;
        logic [4:0]  s_rd;
        logic [2:0]  s_flags;

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_is_store = v.is_store; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_unsigned = v.uns; req_rd = v.rd;
        acc = 0; got = 1'b0; dc_ok = 1'b1; lat_seen = 0;
        for (int c = 0; c < int'(TO) + 6 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            dc_out_rvalid = 1'b0; dc_out_write_done = 1'b0;
            dc_out_rdata = {$urandom, $urandom};
            if (resp_valid) begin
                got = 1'b1;
                lat_seen = c + 1;
                if (dc_en) dc_ok = 1'b0;
            end else if (dc_en) begin
                acc++;
                if (dc_in_addr !== v.addr || dc_write_en !== v.is_store ||
                    dc_in_wlen !== v.size || dc_in_wdata !== v.wdata) dc_ok = 1'b0;
                if (v.is_store) dc_out_rvalid = 1'($urandom_range(0, 1));
                else dc_out_write_done = 1'($urandom_range(0, 1));
                if (acc == v.lat) begin
                    if (v.is_store) dc_out_write_done = 1'b1;
                    else begin dc_out_rvalid = 1'b1; dc_out_rdata = v.raw; end
                end
            end
        end
        dc_out_rvalid = 1'b0; dc_out_write_done = 1'b0;
        chk("resp_valid_seen", got, 1);
        if (!got) begin
            do_reset();
            return;
        end
        exp_acc = v.exp_mis ? 0 : (v.exp_to ? int'(TO) : v.lat);
        chk("latency", 64'(lat_seen), 64'(exp_acc + 1));
        chk("access_cycles", 64'(acc), 64'(exp_acc));
        chk("dc_request_stable", dc_ok, 1);
        chk("resp_rdata", resp_rdata, v.exp_rdata);
        chk("resp_misaligned", resp_misaligned, v.exp_mis);
        chk("resp_timeout", resp_timeout, v.exp_to);
        chk("resp_rd", resp_rd, v.rd);
        chk("resp_is_store", resp_is_store, v.is_store);

        s_rdata = resp_rdata; s_rd = resp_rd;
        s_flags = {resp_is_store, resp_misaligned, resp_timeout};
        stab = 1'b1;
        for (int i = 0; i < v.rdelay; i++) begin
            // A competing op must not be taken while the response is pending.
            req_valid = 1'b1; req_addr = 64'h100; req_size = 2'd0; req_is_store = 1'b0;
            @(negedge clk);
            if (!resp_valid || req_ready || dc_en || resp_rdata !== s_rdata || resp_rd !== s_rd ||
                {resp_is_store, resp_misaligned, resp_timeout} !== s_flags) stab = 1'b0;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        chk("resp_hold_stable", stab, 1);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("back_to_idle", {resp_valid, req_ready, dc_en}, 3'b010);
    endtask

    vec_t vecs[10];

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
        req_unsigned = 1'b0; req_rd = '0; resp_ready = 1'b0;
        dc_out_rdata = '0; dc_out_rvalid = 1'b0; dc_out_write_done = 1'b0;
        #1;
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_dc_en", {dc_en, dc_write_en}, 0);
        chk("reset_outputs", dc_in_addr | dc_in_wdata | resp_rdata, 0);
        chk("reset_flags", {resp_rd, resp_is_store, resp_misaligned, resp_timeout, dc_in_wlen}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        vecs[0] = mk(0, 64'h1003, 0, 2'd0, 0, 5'd1, 1, 64'h80, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
        vecs[1] = mk(0, 64'h1003, 0, 2'd0, 1, 5'd2, 1, 64'h80, 0, 64'h80, 0, 0);
        vecs[2] = mk(1, 64'h2000, 64'hDEADBEEF, 2'd2, 0, 5'd3, 3, 0, 0, 0, 0, 0);
        vecs[3] = mk(0, 64'h1004, 0, 2'd3, 0, 5'd4, 1, 0, 0, 0, 1, 0);
        vecs[4] = mk(0, 64'h3000, 0, 2'd2, 0, 5'd5, 0, 0, 0, 0, 0, 1);
        vecs[5] = mk(0, 64'h10, 0, 2'd1, 0, 5'd6, 2, 64'h1234_5678_9ABC_8001, 5,
                     64'hFFFF_FFFF_FFFF_8001, 0, 0);
        vecs[6] = mk(0, 64'h24, 0, 2'd2, 0, 5'd7, int'(TO), 64'hFFFF_FFFF_7FFF_FFFF, 0,
                     64'h7FFF_FFFF, 0, 0);
        vecs[7] = mk(0, 64'h40, 0, 2'd3, 1, 5'd8, 1, 64'hA5A5_5A5A_F00D_8765, 0,
                     64'hA5A5_5A5A_F00D_8765, 0, 0);
        vecs[8] = mk(1, 64'h5, 64'h1234, 2'd1, 0, 5'd9, 1, 0, 2, 0, 1, 0);
        vecs[9] = mk(0, 64'h8, 0, 2'd2, 1, 5'd10, 4, 64'hFFFF_FFFF_8000_0000, 1,
                     64'h8000_0000, 0, 0);
        foreach (vecs[i]) run_op(vecs[i]);

        // Reset pulsed mid-access drops the cache request and loses the op.
        begin
            logic saw_resp;
            req_valid = 1'b1; req_is_store = 1'b0; req_addr = 64'h7000; req_size = 2'd3;
            req_rd = 5'd20;
            @(negedge clk);
            req_valid = 1'b0;
            repeat (2) @(negedge clk);
            chk("mid_access_dc_en", dc_en, 1);
            #2 reset = 1'b0;
            #1;
            chk("async_reset_dc_en", dc_en, 0);
            chk("async_reset_resp_valid", resp_valid, 0);
            @(negedge clk);
            reset = 1'b1;
            saw_resp = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (resp_valid || dc_en) saw_resp = 1'b1;
            end
            chk("no_resp_after_reset", saw_resp, 0);
            run_op(mk(0, 64'h7008, 0, 2'd2, 0, 5'd21, 2, 64'h0000_0000_8000_0001, 0,
                      64'hFFFF_FFFF_8000_0001, 0, 0));
        end

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            vec_t v;
            logic [63:0] mask;
            int r;
            v.is_store = 1'($urandom_range(0, 1));
            v.size = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom_range(0, 1));
            v.rd = 5'($urandom);
            v.addr = {$urandom, $urandom};
            v.wdata = {$urandom, $urandom};
            v.raw = {$urandom, $urandom};
            mask = 64'((1 << v.size) - 1);
            if ($urandom_range(0, 9) < 7) v.addr = v.addr & ~mask;
            r = int'($urandom_range(0, 9));
            v.lat = (r == 0) ? 0 : (r == 1) ? int'(TO) + 2 : int'($urandom_range(1, TO));
            v.rdelay = int'($urandom_range(0, 3));
            v.exp_mis = (v.addr % (64'd1 << v.size)) != 0;
            v.exp_to = !v.exp_mis && (v.lat == 0 || v.lat > int'(TO));
            v.exp_rdata = (v.exp_mis || v.exp_to || v.is_store) ? 64'd0
                                                                : ref_ext(v.raw, v.size, v.uns);
            run_op(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of ACCESS cycles before an access is abandoned with an error.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory op.
REQ-005 SHALL have port req_ready  output  1  unit accepts an op this cycle.
REQ-006 SHALL have port req_is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  64  byte address.
REQ-008 SHALL have port req_wdata  input  64  store data, low-aligned.
REQ-009 SHALL have port req_size  input  2  log2(bytes): 0=B, 1=H, 2=W, 3=D.
REQ-010 SHALL have port req_unsigned  input  1  zero-extend load (ignored for size 3 and for stores).
REQ-011 SHALL have port req_rd  input  5  destination register tag, returned unchanged.
REQ-012 SHALL have port resp_valid  output  1  result available.
REQ-013 SHALL have port resp_ready  input  1  pipeline consumes result.
REQ-014 SHALL have port resp_rdata  output  64  extended load data; 0 for stores and on error.
REQ-015 SHALL have port resp_rd  output  5  latched req_rd.
REQ-016 SHALL have port resp_is_store  output  1  latched req_is_store.
REQ-017 SHALL have port resp_misaligned  output  1  access not naturally aligned.
REQ-018 SHALL have port resp_timeout  output  1  D-cache did not complete within TIMEOUT cycles.
REQ-019 SHALL have ports dc_en, dc_in_addr[63:0], dc_write_en, dc_in_wdata[63:0], and dc_in_wlen[1:0], all outputs, forming the D-cache request side.
REQ-020 SHALL have ports dc_out_rdata[63:0], dc_out_rvalid, and dc_out_write_done, all inputs; the loaded value occupies dc_out_rdata bits [8*2^size-1:0].

Function
REQ-021 SHALL implement states IDLE, ACCESS, and RESP, encoded in a registered state variable.
REQ-022 SHALL assert req_ready only in IDLE; an op is accepted when req_valid && req_ready; there is no same-cycle bypass.
REQ-023 SHALL, on acceptance, latch addr, wdata, size, unsigned, rd, and is_store.
REQ-024 SHALL treat an op as misaligned when req_addr mod 2^req_size != 0; on acceptance of a misaligned op it SHALL go to RESP with resp_misaligned=1 and SHALL NOT assert dc_en.
REQ-025 SHALL, on acceptance of an aligned op, enter ACCESS in the next cycle.
REQ-026 SHALL, in ACCESS, hold dc_en=1, dc_in_addr=latched addr, dc_write_en=is_store, dc_in_wdata=latched wdata, and dc_in_wlen=latched size, all stable every cycle until completion.
REQ-027 SHALL define completion as dc_out_rvalid for loads or dc_out_write_done for stores; the opposite strobe SHALL be ignored.
REQ-028 SHALL, on completion, capture and extend the data, go to RESP next cycle, and deassert dc_en in that RESP cycle.
REQ-029 SHALL extend loads as follows: sizes 0/1/2 sign-extend from bit 7/15/31, or zero-extend when unsigned=1; size 3 passes through.
REQ-030 SHALL keep a timeout counter that resets to 0 on entry to ACCESS and increments every ACCESS cycle without completion.
REQ-031 SHALL, when the counter equals TIMEOUT-1 without completion, go to RESP with resp_timeout=1 and resp_rdata=0.
REQ-032 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-033 SHALL assert resp_valid only in RESP and hold all resp_* outputs stable until resp_ready=1, then return to IDLE next cycle.
REQ-034 SHALL provide a minimum load/store latency of 2 cycles from acceptance to resp_valid when the D-cache completes in the first ACCESS cycle; a misaligned op SHALL reach resp_valid 1 cycle after acceptance.
REQ-035 SHALL have exactly one op outstanding at any time.

Reset
REQ-036 SHALL, while reset=0 (asynchronously), force state=IDLE, counter=0, resp_valid=0, dc_en=0, dc_write_en=0, and all data, tag, flag, and address outputs to 0; req_ready=1 after reset release.
REQ-037 SHALL, if reset is asserted mid-ACCESS, drop dc_en immediately and discard the op with no response.

Verification
REQ-038 SHALL be verified by: LB at 0x1003 with unsigned=0 and dc_out_rdata=0x80 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80; with unsigned=1 -> 0x80.
REQ-039 SHALL be verified by: SW at 0x2000 with wdata=0xDEADBEEF and write_done after 3 cycles -> dc_in_wlen=2, dc_write_en=1 held 3 cycles, resp_is_store=1, resp_rdata=0.
REQ-040 SHALL be verified by: LD at 0x1004 -> resp_misaligned=1 one cycle after acceptance, dc_en never asserted.
REQ-041 SHALL be verified by: TIMEOUT=8 with the D-cache never responding -> resp_timeout=1 after exactly 8 ACCESS cycles, dc_en low in RESP.
REQ-042 SHALL be verified by: resp_ready held low 5 cycles -> resp_* stable and req_ready=0 throughout; second op accepted only after return to IDLE.
REQ-043 SHALL be verified by: reset=0 pulsed during ACCESS -> dc_en=0 immediately, no resp_valid, next op completes normally.
